// File: rtl/exp2_pipelined.sv
// exp2_pipelined: 3-stage log-to-linear converter.
// DIN = {e[3:0], f[3:0]} in log2 units of 1/16 octave; DOUT = m(f) << (e + 3)
// as 16.8 fixed point. A single advance enable moves the whole pipeline at once,
// so a stalled output freezes every stage, including bubbles.
module exp2_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  DIN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] DOUT
);

  // 6-bit mantissa approximating 32 * 2^(f/16)
  function automatic logic [5:0] mant_lut(input logic [3:0] f);
    logic [5:0] m;
    case (f)
      4'd0:    m = 6'd32;
      4'd1:    m = 6'd33;
      4'd2:    m = 6'd35;
      4'd3:    m = 6'd36;
      4'd4:    m = 6'd38;
      4'd5:    m = 6'd40;
      4'd6:    m = 6'd41;
      4'd7:    m = 6'd43;
      4'd8:    m = 6'd45;
      4'd9:    m = 6'd47;
      4'd10:   m = 6'd49;
      4'd11:   m = 6'd52;
      4'd12:   m = 6'd54;
      4'd13:   m = 6'd56;
      4'd14:   m = 6'd59;
      default: m = 6'd61;
    endcase
    return m;
  endfunction

  // Left shift carried out at the full 24-bit output width; the largest
  // case (61 << 18) still fits, so nothing can be lost off the top.
  function automatic logic [23:0] shl24(input logic [5:0] m, input logic [4:0] s);
    logic [23:0] wide;
    wide = {18'd0, m};
    return wide << s;
  endfunction

  logic        adv;

  logic        vld_p0_q, vld_p0_d;
  logic        vld_p1_q, vld_p1_d;
  logic        vld_p2_q, vld_p2_d;

  logic [7:0]  din_p0_q, din_p0_d;
  logic [5:0]  mant_p1_q, mant_p1_d;
  logic [4:0]  shamt_p1_q, shamt_p1_d;
  logic [23:0] dout_p2_q, dout_p2_d;

  // Advance whenever the output slot is empty or being drained this cycle
  always_comb begin
    adv       = out_ready | ~vld_p2_q;
    in_ready  = adv;
    out_valid = vld_p2_q;
    DOUT      = dout_p2_q;
  end

  // Next-state for valids and data: shift one place on adv, otherwise hold
  always_comb begin
    vld_p0_d   = vld_p0_q;
    vld_p1_d   = vld_p1_q;
    vld_p2_d   = vld_p2_q;
    din_p0_d   = din_p0_q;
    mant_p1_d  = mant_p1_q;
    shamt_p1_d = shamt_p1_q;
    dout_p2_d  = dout_p2_q;
    if (adv) begin
      // S1: capture operand
      vld_p0_d   = in_valid;
      din_p0_d   = DIN;
      // S2: mantissa lookup and shift amount e + 3
      vld_p1_d   = vld_p0_q;
      mant_p1_d  = mant_lut(din_p0_q[3:0]);
      shamt_p1_d = {1'b0, din_p0_q[7:4]} + 5'd3;
      // S3: shifted result, the only source of DOUT
      vld_p2_d   = vld_p1_q;
      dout_p2_d  = shl24(mant_p1_q, shamt_p1_q);
    end
  end

  // Stage valid bits, cleared asynchronously so in-flight operands are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  // Internal data registers; their contents are meaningless while the stage is invalid
  always_ff @(posedge clk) begin
    din_p0_q   <= din_p0_d;
    mant_p1_q  <= mant_p1_d;
    shamt_p1_q <= shamt_p1_d;
  end

  // Output register, forced to zero while in reset so DOUT reads 0 immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_p2_q <= 24'd0;
    end else begin
      dout_p2_q <= dout_p2_d;
    end
  end

endmodule

// File: tb/tb_exp2_pipelined.sv
// Self-checking bench for exp2_pipelined: directed latency, sweep, backpressure,
// reset and round-trip cases, then a long randomized run against a queue scoreboard.
module tb_exp2_pipelined;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  DIN;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] DOUT;

  int n_chk;
  int n_fail;

  exp2_pipelined dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .DIN       (DIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .DOUT      (DOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench must never hang
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: 2^(e + f/16) scaled by 256, using the tabulated mantissa
  function automatic logic [23:0] ref_exp2(input logic [7:0] d);
    int mt [16] = '{32, 33, 35, 36, 38, 40, 41, 43, 45, 47, 49, 52, 54, 56, 59, 61};
    int e;
    int v;
    e = int'(d[7:4]);
    v = mt[d[3:0]] * (1 << (e + 3));
    return 24'(v);
  endfunction

  // Reference log2 block: 1/16-octave code of x/256, clamped to 8 bits
  function automatic logic [7:0] ref_log2(input int x);
    real l;
    int  c;
    l = $ln(real'(x) / 256.0) / $ln(2.0);
    c = int'(l * 16.0 + 0.5);
    if (c > 255) c = 255;
    if (c < 0) c = 0;
    return 8'(c);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One isolated operand: not visible after 1st/2nd edge, present after 3rd
  task automatic single_op(input logic [7:0] d);
    @(negedge clk);
    in_valid  = 1'b1;
    DIN       = d;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    DIN      = 8'hxx;
    chk($sformatf("lat1_vld_%02h", d), out_valid, 1'b0);
    @(negedge clk);
    chk($sformatf("lat2_vld_%02h", d), out_valid, 1'b0);
    @(negedge clk);
    chk($sformatf("lat3_vld_%02h", d), out_valid, 1'b1);
    chk($sformatf("lat3_dout_%02h", d), DOUT, ref_exp2(d));
    @(negedge clk);
    chk($sformatf("lat4_vld_%02h", d), out_valid, 1'b0);
  endtask

  logic [7:0]  bp_vals [3];
  logic [23:0] sb_q [$];

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    DIN       = 8'h00;

    // Reset state, observed with no clock edge needed
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", DOUT, 24'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic values and latency
    single_op(8'h00);
    single_op(8'h08);
    single_op(8'h80);
    single_op(8'hFF);

    // Full sweep back-to-back: operand j appears at iteration j+3
    out_ready = 1'b1;
    for (int c = 0; c < 259; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        chk($sformatf("sweep_vld_%0d", c - 3), out_valid, 1'b1);
        chk($sformatf("sweep_dout_%0d", c - 3), DOUT, ref_exp2(8'(c - 3)));
      end else if (c >= 1) begin
        chk($sformatf("sweep_fill_%0d", c), out_valid, 1'b0);
      end
      in_valid = (c < 256);
      DIN      = 8'(c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sweep_empty", out_valid, 1'b0);

    // Backpressure: out_ready low for iterations 3..7
    bp_vals = '{8'h10, 8'h21, 8'h32};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (c < 3);
      DIN       = (c < 3) ? bp_vals[c] : 8'h00;
      #1;
      if (c >= 3 && c <= 8) begin
        chk($sformatf("bp_hold_vld_%0d", c), out_valid, 1'b1);
        chk($sformatf("bp_hold_dout_%0d", c), DOUT, 24'h000200);
      end
      if (c >= 3 && c <= 7) chk($sformatf("bp_in_ready_%0d", c), in_ready, 1'b0);
      if (c == 9) chk("bp_second", DOUT, ref_exp2(8'h21));
      if (c == 10) chk("bp_third", DOUT, ref_exp2(8'h32));
      if (c == 9 || c == 10) chk($sformatf("bp_vld_%0d", c), out_valid, 1'b1);
      if (c == 11) chk("bp_drained", out_valid, 1'b0);
    end

    // Reset mid-stream with three operands in flight
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      DIN      = 8'h5A + 8'(c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_dout", DOUT, 24'h0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_%0d", c), out_valid, 1'b0);
    end
    single_op(8'h45);

    // Round trip through the reference log2 code
    begin
      int    xs [3] = '{32'h000100, 32'h001680, 32'hFFFFFF};
      logic  [7:0] code;
      real   err;
      for (int i = 0; i < 3; i++) begin
        code = ref_log2(xs[i]);
        @(negedge clk);
        in_valid = 1'b1;
        DIN      = code;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("rt_dout_%0d", i), DOUT, ref_exp2(code));
        err = $ln(real'(DOUT) / real'(xs[i])) / $ln(2.0);
        if (err < 0.0) err = -err;
        // The top-end input saturates the 8-bit log code, so only in-range codes are bounded
        if (code != 8'hFF) chk($sformatf("rt_bound_%0d", i), (err <= 0.0625), 1'b1);
      end
    end

    // Randomized in_valid / out_ready against a scoreboard
    do_reset();
    begin
      int          accepted;
      int          cycles;
      logic        hold_prev;
      logic [23:0] dout_prev;
      accepted  = 0;
      cycles    = 0;
      hold_prev = 1'b0;
      dout_prev = 24'h0;
      sb_q.delete();
      while ((accepted < 10000 || sb_q.size() != 0) && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        if (hold_prev) begin
          chk("rand_hold_vld", out_valid, 1'b1);
          chk("rand_hold_dout", DOUT, dout_prev);
        end
        in_valid  = (accepted < 10000) && ($urandom_range(3, 0) != 0);
        DIN       = 8'($urandom);
        out_ready = ($urandom_range(3, 0) != 0);
        #1;
        chk("rand_in_ready", in_ready, out_ready || !out_valid);
        if (out_valid && out_ready) begin
          chk("rand_sb_nonempty", (sb_q.size() != 0), 1'b1);
          if (sb_q.size() != 0) chk("rand_dout", DOUT, sb_q.pop_front());
        end
        if (in_valid && in_ready) begin
          sb_q.push_back(ref_exp2(DIN));
          accepted++;
        end
        hold_prev = out_valid && !out_ready;
        dout_prev = DOUT;
      end
      chk("rand_accepted", accepted, 10000);
      chk("rand_sb_drained", sb_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
